mgnt_rd_master: RTL and testbench
=================================

Name: mgnt_rd_master

Overview:
- Requester side of the per-port MAC management register bus.
- Takes single register read/write commands from the host side (SPI bridge) and issues a one-cycle sys_req strobe to the MAC management responder.
- Collects the byte-serial, MSB-first read response into one REG_WIDTH word and returns it to the host with a status code.
- Guards the host against a missing, short or overlapping response with a timeout and a busy lockout.

Parameters:
- REG_WIDTH, 32, management register width in bits; multiple of 8, between 8 and 64. NBYTES = REG_WIDTH/8.
- TIMEOUT, 16, max cycles in WAIT before the first response byte; 2..255.
- WR_GAP, 2, cycles held after a write strobe before completion; 1..15.

Ports:
- clk_if  in  1  interface clock
- rst_if  in  1  asynchronous reset, active-low
- host_req_valid  in  1  host command valid
- host_req_ready  out  1  block can accept a command
- host_req_wr  in  1  1=write, 0=read
- host_req_addr  in  8  register address
- host_rsp_valid  out  1  one-cycle completion pulse
- host_rsp_data  out  REG_WIDTH  read data; 0 for writes
- host_rsp_err  out  2  00 ok, 01 timeout, 10 short response
- sys_req_valid  out  1  request strobe to responder
- sys_req_wr  out  1  request direction
- sys_req_addr  out  8  request address
- sys_resp_valid  in  1  response byte valid
- sys_resp_data  in  8  response byte, MSB first

Behaviour:
- Reset (async, rst_if=0): state IDLE; all outputs 0 except host_req_ready=0; byte count, timeout count and shift register cleared. Reset mid-transaction drops the transaction; no host_rsp_valid is produced.
- FSM states: IDLE, REQ, WAIT, RECV, WRDLY, DONE.
- IDLE:
  - host_req_ready = !sys_resp_valid. A stale or overlapping response blocks acceptance.
  - On host_req_valid & host_req_ready: latch wr/addr, clear shift register and counters, go to REQ.
- REQ (exactly 1 cycle):
  - sys_req_valid=1; sys_req_wr/sys_req_addr driven from the latch.
  - sys_req_wr and sys_req_addr hold their latched values until the next accept.
  - Next state: WRDLY if wr, else WAIT.
- WAIT:
  - sys_resp_valid=1: shift in the byte (shreg <= {shreg[REG_WIDTH-9:0], byte}), cnt=1. Go to DONE if NBYTES==1, else RECV.
  - Otherwise tmo++. When tmo reaches TIMEOUT-1 with no byte: go to DONE with err=01, data=0.
- RECV:
  - sys_resp_valid=1: shift in and cnt++. When cnt reaches NBYTES, go to DONE with err=00.
  - sys_resp_valid=0 before NBYTES bytes: go to DONE with err=10. Data = bytes received so far, right-aligned, upper bytes 0.
- WRDLY: hold WR_GAP cycles, then go to DONE with err=00, data=0. Any sys_resp_valid seen here is ignored.
- DONE (1 cycle): host_rsp_valid=1; host_rsp_data/host_rsp_err registered, held stable until the next DONE; then go to IDLE.
- Bytes arriving after NBYTES are not captured. They hold host_req_ready low through IDLE until sys_resp_valid drops.
- host_req_valid in any state other than IDLE is not accepted. The host must hold it until ready.
- Read latency: accept edge → REQ → responder latency L cycles → NBYTES bytes → DONE. host_rsp_valid appears one cycle after the last byte is sampled.
- Counters: cnt is clog2(NBYTES+1) bits; tmo is 8 bits and saturates; no wrap-around is reachable.

Test Plan:
- Read ok: accept read of addr 0x01. Responder waits 2 cycles after the strobe, then drives 0x12,0x34,0x56,0x78 on consecutive cycles → sys_req_valid exactly 1 cycle with addr=0x01, wr=0. host_rsp_valid 1 cycle after byte 0x78, data=0x12345678, err=00.
- Timeout: read of addr 0x10, responder silent, TIMEOUT=16 → host_rsp_valid 16 cycles after the REQ cycle, err=01, data=0; host_req_ready=1 on the next cycle.
- Short response: bytes 0xAB,0xCD, then sys_resp_valid drops → err=10, data=0x0000ABCD.
- Write: write addr 0x0F → sys_req_valid=1 with wr=1; host_rsp_valid WR_GAP+1 cycles after REQ, err=00, data=0. A stray sys_resp_valid pulse during WRDLY does not alter the result.
- Overlap/back-to-back: responder sends 5 bytes, the 5th while the FSM is in DONE/IDLE → result 0x(first four bytes), err=00; host_req_ready stays 0 while sys_resp_valid=1; a second queued host_req_valid is accepted the cycle after sys_resp_valid falls.
- Async reset in RECV after 2 bytes → all outputs 0 immediately, no host_rsp_valid. After release, a normal read returns the correct word.

Source files
------------

// File: rtl/mgnt_rd_master.sv
// Requester side of the MAC management register bus: issues one sys_req strobe per host
// command, assembles the MSB-first byte response and reports data plus a status code.
module mgnt_rd_master #(
   parameter int REG_WIDTH = 32,
   parameter int TIMEOUT   = 16,
   parameter int WR_GAP    = 2
) (
   input  logic                 clk_if,
   input  logic                 rst_if,
   input  logic                 host_req_valid,
   output logic                 host_req_ready,
   input  logic                 host_req_wr,
   input  logic [7:0]           host_req_addr,
   output logic                 host_rsp_valid,
   output logic [REG_WIDTH-1:0] host_rsp_data,
   output logic [1:0]           host_rsp_err,
   output logic                 sys_req_valid,
   output logic                 sys_req_wr,
   output logic [7:0]           sys_req_addr,
   input  logic                 sys_resp_valid,
   input  logic [7:0]           sys_resp_data
);

   localparam int NBYTES = REG_WIDTH / 8;
   localparam int CW     = $clog2(NBYTES + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);
   localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 2);
   localparam logic [7:0]    GAP_LAST = 8'(WR_GAP - 1);

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_TMO   = 2'b01;
   localparam logic [1:0] ERR_SHORT = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_RECV, S_WRDLY, S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic                  live_q;
   logic                  wr_q, wr_d;
   logic [7:0]            addr_q, addr_d;
   logic [REG_WIDTH-1:0]  shreg_q, shreg_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [7:0]            tmo_q, tmo_d;
   logic [REG_WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic [1:0]            rsp_err_q, rsp_err_d;
   logic [REG_WIDTH-1:0]  shifted;
   logic [7:0]            tmo_inc;

   // live_q keeps ready low while reset is asserted even though the state reads IDLE.
   assign host_req_ready = live_q && (state_q == S_IDLE) && !sys_resp_valid;
   assign host_rsp_valid = (state_q == S_DONE);
   assign host_rsp_data  = rsp_data_q;
   assign host_rsp_err   = rsp_err_q;
   assign sys_req_valid  = (state_q == S_REQ);
   assign sys_req_wr     = wr_q;
   assign sys_req_addr   = addr_q;

   assign shifted = (shreg_q << 8) | REG_WIDTH'(sys_resp_data);
   assign tmo_inc = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path infers a latch.
      state_d    = state_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            if (host_req_valid && host_req_ready) begin
               wr_d    = host_req_wr;
               addr_d  = host_req_addr;
               shreg_d = '0;
               cnt_d   = '0;
               tmo_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: state_d = wr_q ? S_WRDLY : S_WAIT;
         S_WAIT: begin
            if (sys_resp_valid) begin
               shreg_d = shifted;
               cnt_d   = CW'(1);
               if (NBYTES == 1) begin
                  rsp_data_d = shifted;
                  rsp_err_d  = ERR_OK;
                  state_d    = S_DONE;
               end else begin
                  state_d = S_RECV;
               end
            end else begin
               tmo_d = tmo_inc;
               // This is the cycle in which the count reaches TIMEOUT-1.
               if (tmo_q >= TMO_LAST) begin
                  rsp_data_d = '0;
                  rsp_err_d  = ERR_TMO;
                  state_d    = S_DONE;
               end
            end
         end
         S_RECV: begin
            if (sys_resp_valid) begin
               shreg_d = shifted;
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  rsp_data_d = shifted;
                  rsp_err_d  = ERR_OK;
                  state_d    = S_DONE;
               end
            end else begin
               rsp_data_d = shreg_q;
               rsp_err_d  = ERR_SHORT;
               state_d    = S_DONE;
            end
         end
         S_WRDLY: begin
            if (tmo_q >= GAP_LAST) begin
               rsp_data_d = '0;
               rsp_err_d  = ERR_OK;
               state_d    = S_DONE;
            end else begin
               tmo_d = tmo_inc;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_if or negedge rst_if) begin
      if (!rst_if) begin
         state_q    <= S_IDLE;
         live_q     <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         shreg_q    <= '0;
         cnt_q      <= '0;
         tmo_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= '0;
      end else begin
         state_q    <= state_d;
         live_q     <= 1'b1;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_mgnt_rd_master.sv
// Directed bench for mgnt_rd_master: stimulus pushes expected strobes/responses into
// queues, a negedge monitor pops and compares whenever the DUT presents them.
module tb_mgnt_rd_master;

   localparam int RW = 32;

   logic          clk_if = 1'b0;
   logic          rst_if = 1'b0;
   logic          host_req_valid = 1'b0;
   logic          host_req_ready;
   logic          host_req_wr = 1'b0;
   logic [7:0]    host_req_addr = 8'h00;
   logic          host_rsp_valid;
   logic [RW-1:0] host_rsp_data;
   logic [1:0]    host_rsp_err;
   logic          sys_req_valid;
   logic          sys_req_wr;
   logic [7:0]    sys_req_addr;
   logic          sys_resp_valid = 1'b0;
   logic [7:0]    sys_resp_data = 8'h00;

   mgnt_rd_master #(.REG_WIDTH(RW), .TIMEOUT(16), .WR_GAP(2)) dut (
      .clk_if         (clk_if),
      .rst_if         (rst_if),
      .host_req_valid (host_req_valid),
      .host_req_ready (host_req_ready),
      .host_req_wr    (host_req_wr),
      .host_req_addr  (host_req_addr),
      .host_rsp_valid (host_rsp_valid),
      .host_rsp_data  (host_rsp_data),
      .host_rsp_err   (host_rsp_err),
      .sys_req_valid  (sys_req_valid),
      .sys_req_wr     (sys_req_wr),
      .sys_req_addr   (sys_req_addr),
      .sys_resp_valid (sys_resp_valid),
      .sys_resp_data  (sys_resp_data)
   );

   always #5 clk_if = ~clk_if;

   typedef struct packed { logic [RW-1:0] data; logic [1:0] err; } rsp_t;
   typedef struct packed { logic wr; logic [7:0] addr; } req_t;

   rsp_t rsp_q[$];
   req_t req_q[$];
   rsp_t exp_rsp;
   req_t exp_req;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: compares every response pulse and every request strobe.
   initial begin
      forever begin
         @(negedge clk_if);
         if (host_rsp_valid) begin
            if (rsp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL rsp_unexpected: got data 0x%0h err %0d, want no response",
                        host_rsp_data, host_rsp_err);
            end else begin
               exp_rsp = rsp_q.pop_front();
               check("rsp_data", 64'(host_rsp_data), 64'(exp_rsp.data));
               check("rsp_err", 64'(host_rsp_err), 64'(exp_rsp.err));
            end
         end
         if (sys_req_valid) begin
            if (req_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL req_unexpected: got strobe addr 0x%0h, want none", sys_req_addr);
            end else begin
               exp_req = req_q.pop_front();
               check("req_wr", 64'(sys_req_wr), 64'(exp_req.wr));
               check("req_addr", 64'(sys_req_addr), 64'(exp_req.addr));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk_if);
      #1;
   endtask

   task automatic idle();
      sys_resp_valid = 1'b0;
      tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      sys_resp_valid = 1'b1;
      sys_resp_data  = b;
      tick();
   endtask

   // Presents a command in an IDLE cycle; returns at the REQ cycle.
   task automatic issue(input logic wr, input logic [7:0] addr, input logic [RW-1:0] data,
                        input logic [1:0] err, input bit want_rsp);
      host_req_valid = 1'b1;
      host_req_wr    = wr;
      host_req_addr  = addr;
      req_q.push_back('{wr: wr, addr: addr});
      if (want_rsp) rsp_q.push_back('{data: data, err: err});
      tick();
      host_req_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, 64'(host_req_ready), 64'd0);
      check({tag, "_rsp_valid"}, 64'(host_rsp_valid), 64'd0);
      check({tag, "_rsp_data"}, 64'(host_rsp_data), 64'd0);
      check({tag, "_rsp_err"}, 64'(host_rsp_err), 64'd0);
      check({tag, "_sys_valid"}, 64'(sys_req_valid), 64'd0);
      check({tag, "_sys_wr"}, 64'(sys_req_wr), 64'd0);
      check({tag, "_sys_addr"}, 64'(sys_req_addr), 64'd0);
   endtask

   initial begin
      #2;
      check_all_zero("reset");
      tick();
      tick();
      rst_if = 1'b1;
      tick();
      #1 check("ready_after_reset", 64'(host_req_ready), 64'd1);

      // Read ok: two idle cycles after the strobe, then four bytes back-to-back.
      issue(1'b0, 8'h01, 32'h12345678, 2'b00, 1'b1);
      idle(); idle(); idle();
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
      #1 check("read_early", 64'(host_rsp_valid), 64'd0);
      send_byte(8'h78);
      sys_resp_valid = 1'b0;
      #1 check("read_done_cycle", 64'(host_rsp_valid), 64'd1);
      tick();
      #1 check("read_ready_after", 64'(host_req_ready), 64'd1);

      // Timeout: silent responder, response 16 cycles after REQ.
      issue(1'b0, 8'h10, 32'h0, 2'b01, 1'b1);
      for (int i = 0; i < 15; i++) idle();
      #1 check("tmo_not_early", 64'(host_rsp_valid), 64'd0);
      idle();
      #1 check("tmo_done_cycle", 64'(host_rsp_valid), 64'd1);
      tick();
      #1 check("tmo_ready_after", 64'(host_req_ready), 64'd1);

      // Short response: two bytes then valid drops.
      issue(1'b0, 8'h22, 32'h0000ABCD, 2'b10, 1'b1);
      idle();
      send_byte(8'hAB); send_byte(8'hCD);
      idle();
      #1 check("short_done_cycle", 64'(host_rsp_valid), 64'd1);
      tick();

      // Write with a stray response pulse during the gap.
      issue(1'b1, 8'h0F, 32'h0, 2'b00, 1'b1);
      idle();
      send_byte(8'hEE);
      sys_resp_valid = 1'b0;
      #1 check("wr_not_early", 64'(host_rsp_valid), 64'd0);
      idle();
      #1 check("wr_done_cycle", 64'(host_rsp_valid), 64'd1);
      tick();

      // Overlap: a fifth byte spills into DONE/IDLE and blocks the next command.
      issue(1'b0, 8'h33, 32'hDEADBEEF, 2'b00, 1'b1);
      idle();
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      sys_resp_valid = 1'b1;
      sys_resp_data  = 8'h99;
      #1 check("ovl_done_cycle", 64'(host_rsp_valid), 64'd1);
      check("ovl_ready_in_done", 64'(host_req_ready), 64'd0);
      tick();
      host_req_valid = 1'b1;
      host_req_wr    = 1'b0;
      host_req_addr  = 8'h44;
      req_q.push_back('{wr: 1'b0, addr: 8'h44});
      rsp_q.push_back('{data: 32'h01020304, err: 2'b00});
      #1 check("ovl_ready_blocked", 64'(host_req_ready), 64'd0);
      tick();
      sys_resp_valid = 1'b0;
      #1 check("ovl_no_accept", 64'(sys_req_valid), 64'd0);
      check("ovl_ready_released", 64'(host_req_ready), 64'd1);
      tick();
      host_req_valid = 1'b0;
      #1 check("ovl_req_strobe", 64'(sys_req_valid), 64'd1);
      idle();
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      sys_resp_valid = 1'b0;
      #1 check("b2b_done_cycle", 64'(host_rsp_valid), 64'd1);
      tick();

      // Async reset in RECV after two bytes drops the transaction.
      issue(1'b0, 8'h55, 32'h0, 2'b00, 1'b0);
      idle();
      send_byte(8'h11); send_byte(8'h22);
      sys_resp_valid = 1'b0;
      rst_if = 1'b0;
      #1 check_all_zero("midrst");
      tick(); tick(); tick();
      #3 rst_if = 1'b1;
      tick();
      tick();
      check("rst_no_rsp", 64'(host_rsp_valid), 64'd0);
      issue(1'b0, 8'h66, 32'hCAFEBABE, 2'b00, 1'b1);
      idle();
      send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
      sys_resp_valid = 1'b0;
      #1 check("post_rst_done_cycle", 64'(host_rsp_valid), 64'd1);
      tick();
      tick();

      check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
      check("req_queue_drained", 64'(req_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
